// File: rtl/muxpc_muxreg_sign_extend_shift_pkg.sv
// Shared widths, reset PC and writeback-select encodings for the next-PC/writeback slice.
package cpu_pkg;
    localparam int unsigned PC_WIDTH     = 32;
    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned OFFSET_WIDTH = 8;

    // -4, so the first fetch after reset is address 0
    localparam logic [PC_WIDTH-1:0] RESET_PC = 32'hFFFF_FFFC;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/muxpc_muxreg_sign_extend_shift_if.sv
// Datapath bundle between control/ALU/memory and the next-PC/writeback slice.
// MUXPC_BNE_EN adds the BNE control input.
interface muxpc_muxreg_sign_extend_shift_if;
    import cpu_pkg::*;

    logic                    BUSYWAIT;
    logic                    JUMP;
    logic                    BEQ;
`ifdef MUXPC_BNE_EN
    logic                    BNE;
`endif
    logic                    ZERO;
    logic [OFFSET_WIDTH-1:0] OFFSET;
    logic [DATA_WIDTH-1:0]   ALU_RESULT;
    logic [DATA_WIDTH-1:0]   READDATA;
    logic                    WRITESEL;
    logic [PC_WIDTH-1:0]     PC;
    logic [PC_WIDTH-1:0]     PC_NEXT;
    logic [PC_WIDTH-1:0]     EXTENDED_SHIFT;
    logic [DATA_WIDTH-1:0]   WB_DATA;

    modport master (
`ifdef MUXPC_BNE_EN
        output BNE,
`endif
        output BUSYWAIT, JUMP, BEQ, ZERO, OFFSET, ALU_RESULT, READDATA, WRITESEL,
        input  PC, PC_NEXT, EXTENDED_SHIFT, WB_DATA
    );

    modport slave (
`ifdef MUXPC_BNE_EN
        input  BNE,
`endif
        input  BUSYWAIT, JUMP, BEQ, ZERO, OFFSET, ALU_RESULT, READDATA, WRITESEL,
        output PC, PC_NEXT, EXTENDED_SHIFT, WB_DATA
    );
endinterface

// File: rtl/muxpc_muxreg_sign_extend_shift_offset_sext_shift.sv
// Sign-extends the signed word offset and scales it to a byte offset (x4).
module offset_sext_shift
    import cpu_pkg::*;
(
    input  logic [OFFSET_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0]     extended
);
    localparam int unsigned ExtBits = PC_WIDTH - OFFSET_WIDTH - 2;

    assign extended = {{ExtBits{offset[OFFSET_WIDTH-1]}}, offset, 2'b00};
endmodule

// File: rtl/muxpc_muxreg_sign_extend_shift.sv
// Program counter, PC+4 / branch-target adders, next-PC mux and writeback mux.
// Optional MUXPC_BNE_EN adds branch-if-not-equal to the next-PC select.
module muxpc_muxreg_sign_extend_shift
    import cpu_pkg::*;
(
    input  logic                                 CLK,
    input  logic                                 RESET,
    muxpc_muxreg_sign_extend_shift_if.slave      bus
);
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] ext_shift;
    logic                sel;

    offset_sext_shift u_sext (
        .offset   (bus.OFFSET),
        .extended (ext_shift)
    );

    // Reset wins over a memory stall
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else if (!bus.BUSYWAIT) begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        pc_plus4 = pc_q + PC_WIDTH'(4);
        target   = pc_plus4 + ext_shift;
`ifdef MUXPC_BNE_EN
        sel      = bus.JUMP | (bus.BEQ & bus.ZERO) | (bus.BNE & ~bus.ZERO);
`else
        sel      = bus.JUMP | (bus.BEQ & bus.ZERO);
`endif
        pc_d     = sel ? target : pc_plus4;
    end

    assign bus.PC             = pc_q;
    assign bus.PC_NEXT        = pc_d;
    assign bus.EXTENDED_SHIFT = ext_shift;
    assign bus.WB_DATA        = (bus.WRITESEL == WB_SEL_MEM) ? bus.READDATA : bus.ALU_RESULT;
endmodule

// File: tb/tb_muxpc_muxreg_sign_extend_shift.sv
// Directed bench for the next-PC / writeback slice; define MUXPC_BNE_EN to cover BNE.
module tb_muxpc_muxreg_sign_extend_shift;
    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_fail;

    muxpc_muxreg_sign_extend_shift_if bus ();

    muxpc_muxreg_sign_extend_shift dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET = 1'b1;
        bus.BUSYWAIT   = 1'b0;
        bus.JUMP       = 1'b0;
        bus.BEQ        = 1'b0;
`ifdef MUXPC_BNE_EN
        bus.BNE        = 1'b0;
`endif
        bus.ZERO       = 1'b0;
        bus.OFFSET     = 8'h00;
        bus.ALU_RESULT = 8'h00;
        bus.READDATA   = 8'h00;
        bus.WRITESEL   = 1'b0;

        // Reset and sequential fetch, including the -4 -> 0 wrap
        tick();
        chk("reset_pc", bus.PC, 32'hFFFF_FFFC);
        chk("reset_pc_next", bus.PC_NEXT, 32'h0000_0000);
        RESET = 1'b0;
        tick();
        chk("seq_pc0", bus.PC, 32'h0000_0000);
        tick();
        chk("seq_pc4", bus.PC, 32'h0000_0004);

        // Forward jump
        bus.JUMP   = 1'b1;
        bus.OFFSET = 8'h02;
        #1;
        chk("fwd_ext", bus.EXTENDED_SHIFT, 32'h0000_0008);
        chk("fwd_next", bus.PC_NEXT, 32'h0000_0010);
        tick();
        chk("fwd_pc", bus.PC, 32'h0000_0010);
        bus.JUMP = 1'b0;

        // Backward branch taken / not taken
        bus.BEQ    = 1'b1;
        bus.ZERO   = 1'b1;
        bus.OFFSET = 8'hFE;
        #1;
        chk("bwd_ext", bus.EXTENDED_SHIFT, 32'hFFFF_FFF8);
        chk("beq_taken_next", bus.PC_NEXT, 32'h0000_000C);
        bus.ZERO = 1'b0;
        #1;
        chk("beq_not_taken_next", bus.PC_NEXT, 32'h0000_0014);
        bus.ZERO = 1'b1;
        tick();
        chk("beq_pc", bus.PC, 32'h0000_000C);
        tick();
        chk("beq_pc2", bus.PC, 32'h0000_0008);
        bus.BEQ  = 1'b0;
        bus.ZERO = 1'b0;

        // Stall holds PC; reset during stall still loads RESET_PC
        bus.BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.PC, 32'h0000_0008);
        end
        RESET = 1'b1;
        tick();
        chk("stall_reset_pc", bus.PC, 32'hFFFF_FFFC);
        chk("stall_reset_next", bus.PC_NEXT, 32'h0000_0000);
        RESET = 1'b0;
        tick();
        chk("stall_after_reset", bus.PC, 32'hFFFF_FFFC);
        bus.BUSYWAIT = 1'b0;

        // Writeback mux, no clock involved
        bus.ALU_RESULT = 8'h5A;
        bus.READDATA   = 8'hA5;
        bus.WRITESEL   = 1'b0;
        #1;
        chk("wb_alu", {24'h0, bus.WB_DATA}, 32'h0000_005A);
        bus.WRITESEL = 1'b1;
        #1;
        chk("wb_mem", {24'h0, bus.WB_DATA}, 32'h0000_00A5);

        // Offset extremes and JUMP+BEQ together with ZERO low
        bus.OFFSET = 8'h7F;
        #1;
        chk("ext_max", bus.EXTENDED_SHIFT, 32'h0000_01FC);
        bus.OFFSET = 8'h80;
        #1;
        chk("ext_min", bus.EXTENDED_SHIFT, 32'hFFFF_FE00);
        bus.JUMP   = 1'b1;
        bus.BEQ    = 1'b1;
        bus.OFFSET = 8'h03;
        #1;
        chk("jump_beq_next", bus.PC_NEXT, 32'h0000_000C);
        tick();
        chk("jump_beq_pc", bus.PC, 32'h0000_000C);
        bus.JUMP = 1'b0;
        bus.BEQ  = 1'b0;
        bus.ZERO = 1'b1;
        #1;
        chk("seq_next", bus.PC_NEXT, 32'h0000_0010);

`ifdef MUXPC_BNE_EN
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        chk("bne_pc0", bus.PC, 32'h0000_0000);
        bus.BNE    = 1'b1;
        bus.ZERO   = 1'b0;
        bus.OFFSET = 8'h01;
        #1;
        chk("bne_taken_next", bus.PC_NEXT, 32'h0000_0008);
        bus.ZERO = 1'b1;
        #1;
        chk("bne_not_taken_next", bus.PC_NEXT, 32'h0000_0004);
        bus.BNE = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muxpc_muxreg_sign_extend_shift.md
Name: muxpc_muxreg_sign_extend_shift

Overview:
- Next-PC and register-writeback datapath slice of the single-cycle 8-bit processor.
- Holds the 32-bit program counter and computes PC+4.
- Sign-extends the 8-bit branch/jump offset, multiplies it by 4 and adds it to PC+4 to form the branch target.
- Selects sequential vs. target PC, and selects the register-file write data (ALU result vs. memory read data).

Parameters:
- PC_WIDTH, 32, width of PC, PC+4, target and extended offset.
- DATA_WIDTH, 8, width of ALU result, memory read data and writeback data.
- RESET_PC, 32'hFFFFFFFC, PC value loaded by reset (-4, so the first fetch after reset is address 0).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- BUSYWAIT  input  1  memory stall; when high, PC holds.
- JUMP  input  1  unconditional jump from control unit.
- BEQ  input  1  branch-if-equal from control unit.
- ZERO  input  1  ALU zero flag.
- OFFSET  input  8  signed word offset (instruction destination field).
- ALU_RESULT  input  DATA_WIDTH  ALU output.
- READDATA  input  DATA_WIDTH  data-memory read data.
- WRITESEL  input  1  writeback select: 1 = READDATA, 0 = ALU_RESULT.
- PC  output  PC_WIDTH  current program counter (registered).
- PC_NEXT  output  PC_WIDTH  value PC will load on the next unstalled edge.
- EXTENDED_SHIFT  output  PC_WIDTH  sign-extended, shifted offset.
- WB_DATA  output  DATA_WIDTH  register-file write data.

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous and active-high. On a rising CLK with RESET=1, PC <= RESET_PC. RESET has priority over BUSYWAIT.
- PC update: on a rising CLK with RESET=0 and BUSYWAIT=0, PC <= PC_NEXT. With BUSYWAIT=1, PC holds.
- Reset mid-operation (including during a stall) loads RESET_PC on that edge.
- EXTENDED_SHIFT = {{22{OFFSET[7]}}, OFFSET, 2'b00}. Combinational. Range -512..+508.
- PC_PLUS4 = PC + 4 and TARGET = PC_PLUS4 + EXTENDED_SHIFT. Both are internal and modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000, and no overflow flag is produced.
- SEL = JUMP | (BEQ & ZERO).
  - PC_NEXT = SEL ? TARGET : PC_PLUS4.
  - JUMP and BEQ both high is legal; the result is still the jump.
- WB_DATA = WRITESEL ? READDATA : ALU_RESULT. Purely combinational, zero latency.
- Output values during and after reset:
  - PC = 0xFFFFFFFC.
  - PC_NEXT = 0x00000000 when SEL = 0.
  - EXTENDED_SHIFT and WB_DATA follow their inputs.
- No internal delays; all combinational outputs settle within the same cycle.

Optional Feature:
- Macro: MUXPC_BNE_EN.
- When defined:
  - Adds input port BNE (1 bit).
  - SEL = JUMP | (BEQ & ZERO) | (BNE & ~ZERO).
- When undefined: no BNE port, and SEL is as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package (cpu_pkg) holds:
  - PC_WIDTH, DATA_WIDTH, RESET_PC.
  - OFFSET_WIDTH = 8.
  - WB_SEL_ALU = 0 and WB_SEL_MEM = 1 constants.
- One natural sub-module: offset_sext_shift (8-bit offset -> 32-bit sign-extended, shifted by 2).
- The PC register, adders and the two muxes live in the top.

Test Plan:
- Reset: RESET=1 for one edge -> PC = 0xFFFFFFFC. Release and clock twice -> PC = 0x00000000, then 0x00000004.
- Forward jump: PC=0x04, JUMP=1, OFFSET=0x02 -> EXTENDED_SHIFT = 0x00000008, PC_NEXT = 0x10; PC = 0x10 after the edge.
- Backward branch: PC=0x10, BEQ=1, ZERO=1, OFFSET=0xFE -> EXTENDED_SHIFT = 0xFFFFFFF8, PC_NEXT = 0x0C. Same with ZERO=0 -> PC_NEXT = 0x14.
- Stall: BUSYWAIT=1 for 3 edges at PC=0x08 -> PC stays 0x08. Assert RESET during the stall -> PC = 0xFFFFFFFC on that edge.
- Writeback mux: ALU_RESULT=0x5A, READDATA=0xA5. WRITESEL=0 -> WB_DATA = 0x5A; WRITESEL=1 -> WB_DATA = 0xA5, with no clock needed.
- BNE build (MUXPC_BNE_EN defined): PC=0x00, BNE=1, ZERO=0, OFFSET=0x01 -> PC_NEXT = 0x08. With ZERO=1 -> PC_NEXT = 0x04.
